mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its data port. It sits between the rv32i core's memory-side outputs and the memory. For every pipeline step it performs the pending data access, if any, then the instruction fetch. It holds the pipeline with a global stall until both accesses complete, then presents the instruction word and the data read word for exactly one cycle.

## Interface

Parameters:
- ADDR_W, 32, address width of the core and memory ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-high reset.
- PCF  in  32  fetch address from the core.
- ALUResultM  in  32  data address.
- WriteDataM  in  32  store data.
- MemWriteM  in  1  store request for the current step.
- MemReadM  in  1  load request for the current step.
- byteEnable  in  4  store byte lanes.
- RD_instr  out  32  fetched instruction, valid when stall=0.
- RD_data  out  32  load data, valid when stall=0.
- stall  out  1  global pipeline hold; the pipeline advances only on edges where stall=0.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address; bits [1:0] are always 0.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte lanes; 4'b1111 for reads.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  accept/complete; may be high in the first request cycle (zero wait).

## Operation

- States: IDLE, DATA_WAIT, FETCH_WAIT, RELEASE.
- **IDLE:**
  - If MemWriteM or MemReadM is set, issue the data transaction combinationally: mem_req=1, addr=ALUResultM, we=MemWriteM. Then:
    - mem_ready=1: go to FETCH_WAIT.
    - mem_ready=0: go to DATA_WAIT.
  - Otherwise issue the fetch: addr=PCF, we=0. Then:
    - mem_ready=1: go to RELEASE.
    - mem_ready=0: go to FETCH_WAIT.
- **DATA_WAIT:** request held stable. On mem_ready go to FETCH_WAIT.
- **FETCH_WAIT:** fetch request at PCF, we=0, be=4'b1111. On mem_ready go to RELEASE.
- **RELEASE:** mem_req=0, stall=0. Go to IDLE.
- **Request latching:** on issue, the data request fields (address, data, be, we) are latched into a request register. DATA_WAIT drives the memory from these registers, so the memory sees a stable request regardless of input glitches.
- **Result capture:**
  - mem_rdata is captured into the data buffer on a load's completion cycle.
  - mem_rdata is captured into the instruction buffer on fetch completion.
  - RD_instr and RD_data drive from these buffers. They change only on completion edges.
- A store leaves RD_data unchanged.
- **Illegal input:** MemWriteM and MemReadM both set is treated as a store.
- stall=1 in every state except RELEASE.

## Timing

- **Reset values:**
  - state IDLE
  - mem_req 0 during the clr cycle; from the following IDLE cycle mem_req follows the IDLE issue rule.
  - stall 1
  - RD_instr 32'h00000013 (NOP)
  - RD_data 0
  - request registers 0
- **Reset mid-transaction:** an in-flight request is abandoned. A mem_ready arriving in the clr cycle is ignored.
- **Step latency** (n = memory wait states per access):
  - fetch-only step: 2+n cycles
  - load/store step: 3+n_data+n_fetch cycles
- **Minimum step rates:**
  - fetch-only: one pipeline advance per 2 cycles.
  - load/store: one pipeline advance per 3 cycles.
- The core inputs must be stable while stall=1. The pipeline guarantees this because stall freezes it.
- mem_addr, mem_we, mem_wdata and mem_be must not change while mem_req=1 and mem_ready=0.

## Configuration

- Macro: MEM_ARB_IFETCH_BUF_EN.
- **Defined:** a one-entry fetch buffer is compiled in. It holds the last fetched word address and a valid bit.
  - In IDLE or on leaving DATA_WAIT: if PCF[ADDR_W-1:2] matches the buffered address and valid=1, the fetch is skipped and the arbiter goes straight to RELEASE with RD_instr unchanged.
  - A completed store whose word address matches clears valid.
  - clr clears valid.
- **Undefined:** every step performs a fetch.

## Structure

- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, DATA_WAIT, FETCH_WAIT, RELEASE)
  - NOP_INSTR = 32'h00000013
  - BE_FULL = 4'b1111
- Sub-module ifetch_buf: holds the tag register, the valid bit, the hit compare and the store-invalidate logic. It is instantiated only under MEM_ARB_IFETCH_BUF_EN.

## Test plan

- **Fetch-only, zero wait:** mem_ready=1, PCF=0x100, mem_rdata=0x00500093 → mem_req=1, addr=0x100 in cycle 0; stall=0, RD_instr=0x00500093 in cycle 1; repeats every 2 cycles.
- **Store:** MemWriteM=1, ALUResultM=0x2004, WriteDataM=0xDEADBEEF, byteEnable=4'b0011, zero wait:
  - cycle 0: we=1, addr=0x2004, be=4'b0011
  - cycle 1: fetch with be=4'b1111
  - cycle 2: stall=0
  - RD_data unchanged throughout.
- **Load, 3 wait states:** MemReadM=1, ALUResultM=0x3000, mem_ready after 3 cycles with mem_rdata=0x12345678 → request fields stable for 4 cycles; RD_data=0x12345678 in the RELEASE cycle.
- **Reset in DATA_WAIT:** assert clr → next cycle state IDLE, stall=1, RD_instr=0x00000013, RD_data=0; the late mem_ready is ignored.
- **With MEM_ARB_IFETCH_BUF_EN:**
  - Two steps with the same PCF=0x40 → the second step has no mem_req and RELEASE follows IDLE.
  - A store to 0x40 followed by a step at PCF=0x40 → the fetch is reissued.
- **Simultaneous MemWriteM and MemReadM:** → the transaction is a write (mem_we=1); RD_data unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_WAIT  = 2'd1,
        FETCH_WAIT = 2'd2,
        RELEASE    = 2'd3
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [3:0]  BE_FULL   = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_ifetch_buf.sv
// One-entry fetch buffer: last fetched word address plus valid bit.
// Compiled only when MEM_ARB_IFETCH_BUF_EN is defined.
`ifdef MEM_ARB_IFETCH_BUF_EN
module ifetch_buf #(
    parameter int TAG_W = 30
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [TAG_W-1:0] pcWord,
    input  logic             fillEn,
    input  logic             storeEn,
    input  logic [TAG_W-1:0] storeWord,
    output logic             hit
);

    logic [TAG_W-1:0] tagReg;
    logic             validReg;
    logic             storeKills;

    // A store completing this cycle to the buffered word already counts as a miss.
    assign storeKills = storeEn && (storeWord == tagReg);
    assign hit        = validReg && (pcWord == tagReg) && !storeKills;

    always_ff @(posedge clk) begin
        if (clr) begin
            tagReg   <= '0;
            validReg <= 1'b0;
        end else if (fillEn) begin
            tagReg   <= pcWord;
            validReg <= 1'b1;
        end else if (storeKills) begin
            validReg <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Sequences the data access then the instruction fetch of each pipeline step onto
// one shared memory port. Optional fetch buffer: MEM_ARB_IFETCH_BUF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       PCF,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [3:0]        byteEnable,
    output logic [31:0]       RD_instr,
    output logic [31:0]       RD_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        stateReg;
    logic              stallReg;
    logic [31:0]       instrReg;
    logic [31:0]       dataReg;
    logic [ADDR_W-1:0] reqAddrReg;
    logic [31:0]       reqWdataReg;
    logic [3:0]        reqBeReg;
    logic              reqWeReg;

    logic              dataReq;
    logic              fetchHit;
    logic [ADDR_W-1:0] dataAddr;
    logic [ADDR_W-1:0] fetchAddr;
    logic              unusedLowBits;

    assign dataReq       = MemWriteM | MemReadM;
    assign dataAddr      = {ALUResultM[ADDR_W-1:2], 2'b00};
    assign fetchAddr     = {PCF[ADDR_W-1:2], 2'b00};
    assign unusedLowBits = ^{PCF[1:0], ALUResultM[1:0]};

    assign RD_instr = instrReg;
    assign RD_data  = dataReg;
    assign stall    = stallReg;

`ifdef MEM_ARB_IFETCH_BUF_EN
    logic              storeDone;
    logic              fetchDone;
    logic [ADDR_W-3:0] storeWord;

    // Completion strobes are decoded from state, not from mem_req, to keep hit off any loop.
    assign storeDone = !clr && mem_ready &&
                       ((stateReg == IDLE && MemWriteM) || (stateReg == DATA_WAIT && reqWeReg));
    assign storeWord = (stateReg == IDLE) ? dataAddr[ADDR_W-1:2] : reqAddrReg[ADDR_W-1:2];
    assign fetchDone = !clr && mem_ready &&
                       ((stateReg == IDLE && !dataReq && !fetchHit) || stateReg == FETCH_WAIT);

    ifetch_buf #(
        .TAG_W(ADDR_W - 2)
    ) u_ifetch_buf (
        .clk      (clk),
        .clr      (clr),
        .pcWord   (PCF[ADDR_W-1:2]),
        .fillEn   (fetchDone),
        .storeEn  (storeDone),
        .storeWord(storeWord),
        .hit      (fetchHit)
    );
`else
    assign fetchHit = 1'b0;
`endif

    // Memory port: IDLE issues straight from the core, DATA_WAIT from the latched request.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fetchAddr;
        mem_wdata = reqWdataReg;
        mem_be    = BE_FULL;
        case (stateReg)
            IDLE: begin
                if (dataReq) begin
                    mem_req   = 1'b1;
                    mem_we    = MemWriteM;
                    mem_addr  = dataAddr;
                    mem_wdata = WriteDataM;
                    mem_be    = MemWriteM ? byteEnable : BE_FULL;
                end else if (!fetchHit) begin
                    mem_req = 1'b1;
                end
            end
            DATA_WAIT: begin
                mem_req  = 1'b1;
                mem_we   = reqWeReg;
                mem_addr = reqAddrReg;
                mem_be   = reqBeReg;
            end
            FETCH_WAIT: mem_req = 1'b1;
            default: ;
        endcase
        if (clr) begin
            mem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stateReg    <= IDLE;
            stallReg    <= 1'b1;
            instrReg    <= NOP_INSTR;
            dataReg     <= '0;
            reqAddrReg  <= '0;
            reqWdataReg <= '0;
            reqBeReg    <= '0;
            reqWeReg    <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (dataReq) begin
                        reqAddrReg  <= dataAddr;
                        reqWdataReg <= WriteDataM;
                        reqBeReg    <= MemWriteM ? byteEnable : BE_FULL;
                        reqWeReg    <= MemWriteM;
                        if (mem_ready) begin
                            if (!MemWriteM) begin
                                dataReg <= mem_rdata;
                            end
                            if (fetchHit) begin
                                stateReg <= RELEASE;
                                stallReg <= 1'b0;
                            end else begin
                                stateReg <= FETCH_WAIT;
                            end
                        end else begin
                            stateReg <= DATA_WAIT;
                        end
                    end else if (fetchHit) begin
                        stateReg <= RELEASE;
                        stallReg <= 1'b0;
                    end else if (mem_ready) begin
                        instrReg <= mem_rdata;
                        stateReg <= RELEASE;
                        stallReg <= 1'b0;
                    end else begin
                        stateReg <= FETCH_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (mem_ready) begin
                        if (!reqWeReg) begin
                            dataReg <= mem_rdata;
                        end
                        if (fetchHit) begin
                            stateReg <= RELEASE;
                            stallReg <= 1'b0;
                        end else begin
                            stateReg <= FETCH_WAIT;
                        end
                    end
                end
                FETCH_WAIT: begin
                    if (mem_ready) begin
                        instrReg <= mem_rdata;
                        stateReg <= RELEASE;
                        stallReg <= 1'b0;
                    end
                end
                RELEASE: begin
                    stateReg <= IDLE;
                    stallReg <= 1'b1;
                end
                default: begin
                    stateReg <= IDLE;
                    stallReg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory responder plus a queue of
// expected memory transactions and expected step results.
module tb_mem_port_arbiter;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
    } tx_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] PCF = '0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] RD_instr;
    logic [31:0] RD_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int          nCompared = 0;
    int          nMismatched = 0;
    tx_t         txQ[$];
    logic [31:0] expInstr = NOP;
    logic [31:0] expData = '0;
    logic [29:0] bufTag = '0;
    logic        bufValid = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .PCF       (PCF),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .MemWriteM (MemWriteM),
        .MemReadM  (MemReadM),
        .byteEnable(byteEnable),
        .RD_instr  (RD_instr),
        .RD_data   (RD_data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // One pipeline step: queue the expected memory traffic, then serve it until release.
    task automatic do_step(input string name, input logic [31:0] pc, input logic wr,
                           input logic rd, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [3:0] be, input int nd, input int nf,
                           input logic [31:0] rdD, input logic [31:0] rdF);
        tx_t  t;
        bit   doFetch;
        bit   done;
        int   expLat;
        int   waitCnt;
        logic dataReq;
        dataReq = wr | rd;
        if (dataReq) begin
            t.addr  = {alu[31:2], 2'b00};
            t.we    = wr;
            t.be    = wr ? be : 4'b1111;
            t.wdata = wd;
            t.waits = nd;
            t.rdata = rdD;
            txQ.push_back(t);
        end
        doFetch = 1'b1;
        if (wr && bufValid && alu[31:2] == bufTag) bufValid = 1'b0;
`ifdef MEM_ARB_IFETCH_BUF_EN
        if (bufValid && bufTag == pc[31:2]) doFetch = 1'b0;
`endif
        if (doFetch) begin
            t.addr  = {pc[31:2], 2'b00};
            t.we    = 1'b0;
            t.be    = 4'b1111;
            t.wdata = '0;
            t.waits = nf;
            t.rdata = rdF;
            txQ.push_back(t);
            bufTag   = pc[31:2];
            bufValid = 1'b1;
        end
        if (rd && !wr) expData = rdD;
        if (doFetch) expInstr = rdF;
        expLat = 2 + (dataReq ? nd : 0) + (doFetch ? nf : 0) + ((dataReq && doFetch) ? 1 : 0);

        waitCnt = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                clr        = 1'b0;
                PCF        = pc;
                MemWriteM  = wr;
                MemReadM   = rd;
                ALUResultM = alu;
                WriteDataM = wd;
                byteEnable = be;
            end
            #1;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                nCompared++;
                if (txQ.size() == 0) begin
                    nMismatched++;
                    $display("FAIL %s unexpected_req cyc=%0d got addr=%h we=%b", name, cyc, mem_addr, mem_we);
                end else begin
                    if (mem_addr !== txQ[0].addr || mem_we !== txQ[0].we || mem_be !== txQ[0].be ||
                        (txQ[0].we && mem_wdata !== txQ[0].wdata)) begin
                        nMismatched++;
                        $display("FAIL %s req_fields cyc=%0d got addr=%h we=%b be=%b wd=%h want addr=%h we=%b be=%b wd=%h",
                                 name, cyc, mem_addr, mem_we, mem_be, mem_wdata,
                                 txQ[0].addr, txQ[0].we, txQ[0].be, txQ[0].wdata);
                    end
                    if (waitCnt == txQ[0].waits) begin
                        mem_ready = 1'b1;
                        mem_rdata = txQ[0].rdata;
                        void'(txQ.pop_front());
                        waitCnt = 0;
                    end else begin
                        waitCnt++;
                    end
                end
            end
            if (stall === 1'b0) begin
                done = 1'b1;
                nCompared++;
                if (cyc + 1 != expLat) begin
                    nMismatched++;
                    $display("FAIL %s latency got %0d want %0d", name, cyc + 1, expLat);
                end
                nCompared++;
                if (RD_instr !== expInstr) begin
                    nMismatched++;
                    $display("FAIL %s RD_instr got %h want %h", name, RD_instr, expInstr);
                end
                nCompared++;
                if (RD_data !== expData) begin
                    nMismatched++;
                    $display("FAIL %s RD_data got %h want %h", name, RD_data, expData);
                end
                nCompared++;
                if (mem_req !== 1'b0 || txQ.size() != 0) begin
                    nMismatched++;
                    $display("FAIL %s release got mem_req=%b pending=%0d want mem_req=0 pending=0",
                             name, mem_req, txQ.size());
                end
                $display("step %s pc=%h wr=%b rd=%b alu=%h lat=%0d instr=%h data=%h",
                         name, pc, wr, rd, alu, cyc + 1, RD_instr, RD_data);
            end
        end
        if (!done) begin
            nCompared++;
            nMismatched++;
            $display("FAIL %s timeout got no release want release after %0d cycles", name, expLat);
            txQ.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        nCompared++;
        if (mem_req !== 1'b0 || stall !== 1'b1 || RD_instr !== NOP || RD_data !== 32'h0) begin
            nMismatched++;
            $display("FAIL reset got req=%b stall=%b instr=%h data=%h want 0 1 %h 0",
                     mem_req, stall, RD_instr, RD_data, NOP);
        end
        $display("reset req=%b stall=%b instr=%h data=%h", mem_req, stall, RD_instr, RD_data);
    endtask

    task automatic test_fetch_zero_wait();
        do_step("fetch0_a", 32'h100, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h00500093);
        do_step("fetch0_b", 32'h104, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h00A00113);
        do_step("fetch0_c", 32'h108, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h002081B3);
    endtask

    task automatic test_fetch_waits();
        do_step("fetch_w2", 32'h200, 0, 0, 0, 0, 4'h0, 0, 2, 0, 32'h11112222);
    endtask

    task automatic test_store();
        do_step("store", 32'h10C, 1, 0, 32'h2004, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 32'h00000513);
    endtask

    task automatic test_load_waits();
        do_step("load_w3", 32'h110, 0, 1, 32'h3000, 0, 4'h0, 3, 0, 32'h12345678, 32'h00000593);
        do_step("load_low_bits", 32'h114, 0, 1, 32'h3007, 0, 4'h0, 1, 1, 32'hCAFEF00D, 32'h00C00613);
    endtask

    task automatic test_write_and_read();
        do_step("wr_and_rd", 32'h118, 1, 1, 32'h2008, 32'hA5A5A5A5, 4'b1100, 1, 0, 32'hFFFFFFFF, 32'h00D00693);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] pc;
            logic [31:0] alu;
            logic        wr;
            logic        rd;
            pc  = 32'h40 + 32'($urandom_range(0, 2)) * 4;
            alu = 32'h40 + 32'($urandom_range(0, 3)) * 4;
            wr  = 1'($urandom_range(0, 3) == 0);
            rd  = 1'($urandom_range(0, 2) == 0);
            do_step($sformatf("b2b_%0d", i), pc, wr, rd, alu, $urandom, 4'($urandom_range(1, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
        end
    endtask

    task automatic test_reset_in_data_wait();
        @(negedge clk);
        clr = 1'b0; PCF = 32'h300; MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h3000;
        mem_ready = 1'b0;
        #1;
        nCompared++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin
            nMismatched++;
            $display("FAIL rst_dw issue got req=%b addr=%h want 1 00003000", mem_req, mem_addr);
        end
        @(negedge clk);
        #1;
        nCompared++;
        if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== 32'h3000) begin
            nMismatched++;
            $display("FAIL rst_dw hold got req=%b stall=%b addr=%h want 1 1 00003000", mem_req, stall, mem_addr);
        end
        @(negedge clk);
        clr = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBADC0DE5;
        #1;
        nCompared++;
        if (mem_req !== 1'b0) begin
            nMismatched++;
            $display("FAIL rst_dw clr_cycle_req got %b want 0", mem_req);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nCompared++;
        if (stall !== 1'b1 || RD_instr !== NOP || RD_data !== 32'h0 || mem_req !== 1'b0) begin
            nMismatched++;
            $display("FAIL rst_dw after got stall=%b instr=%h data=%h req=%b want 1 %h 0 0",
                     stall, RD_instr, RD_data, mem_req, NOP);
        end
        $display("reset_in_data_wait stall=%b instr=%h data=%h", stall, RD_instr, RD_data);
        MemReadM = 1'b0;
        txQ.delete();
        expInstr = NOP;
        expData  = '0;
        bufValid = 1'b0;
    endtask

    task automatic test_fetch_buf();
        do_step("fbuf_fill", 32'h40, 0, 0, 0, 0, 4'h0, 0, 1, 0, 32'h04000013);
        do_step("fbuf_same", 32'h40, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h0BADBAD0);
        do_step("fbuf_load", 32'h40, 0, 1, 32'h40, 0, 4'h0, 2, 0, 32'h55667788, 32'h0BADBAD1);
        do_step("fbuf_store_other", 32'h40, 1, 0, 32'h80, 32'h01020304, 4'b1111, 0, 0, 0, 32'h0BADBAD2);
        do_step("fbuf_store_hit", 32'h40, 1, 0, 32'h40, 32'h0A0B0C0D, 4'b0001, 1, 1, 0, 32'h04100013);
        do_step("fbuf_after_store", 32'h40, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h04200013);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_fetch_waits();
        test_store();
        test_load_waits();
        test_write_and_read();
        test_back_to_back();
        test_reset_in_data_wait();
        test_fetch_buf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
